ioctl_sender: RTL

IOCTL_SENDER -- requirements
Module: ioctl_sender

---
 rtl/ioctl_pkg.sv | 16 +
 rtl/ioctl_sender.sv | 107 ++++++++++
 2 files changed

// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download path: FSM state encoding and default
// write spacing, reused by both the sender and receiver-side blocks.
package ioctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_HOLD   = 3'd4,
        ST_FINISH = 3'd5
    } ioctl_state_t;

    localparam int IOCTL_WR_GAP_DEFAULT = 3;

endpackage

// File: rtl/ioctl_sender.sv
// Streams a byte source into the ioctl download interface, one ioctl_wr pulse per
// byte, with a minimum pulse spacing and core back-pressure via ioctl_wait.
module ioctl_sender
    import ioctl_pkg::*;
#(
    parameter int WR_GAP = IOCTL_WR_GAP_DEFAULT,
    parameter int ADDR_W = 25
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] length,
    input  logic              abort,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              src_ready,
    output logic              ioctl_download,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic              ioctl_wait,
    output logic              busy,
    output logic              done
);

    localparam int GAP_EFF  = (WR_GAP < 1) ? 1 : WR_GAP;
    // WRITE -> HOLD -> FETCH -> WRITE already spans 3 cycles; HOLD only pads beyond that.
    localparam int HOLD_MIN = (GAP_EFF > 3) ? GAP_EFF - 2 : 1;
    localparam int GAP_W    = $clog2(HOLD_MIN + 1);

    ioctl_state_t      state_q, state_d;
    logic [ADDR_W-1:0] length_q;
    logic [ADDR_W-1:0] byte_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              gap_ok;
    logic              src_hs;

    assign gap_ok         = (gap_cnt >= GAP_W'(HOLD_MIN));
    assign src_ready      = (state_q == ST_FETCH) && !abort;
    assign src_hs         = src_ready && src_valid;
    assign ioctl_wr       = (state_q == ST_WRITE) && !ioctl_wait;
    assign ioctl_download = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_FINISH);

    // NOTE: state_d gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_ARM;
            ST_ARM: begin
                if (abort || length_q == '0) state_d = ST_FINISH;
                else                         state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (abort)          state_d = ST_FINISH;
                else if (src_valid) state_d = ST_WRITE;
            end
            // A stalled write still completes before an abort takes effect.
            ST_WRITE:  if (!ioctl_wait) state_d = abort ? ST_FINISH : ST_HOLD;
            ST_HOLD: begin
                if (abort)                          state_d = ST_FINISH;
                else if (gap_ok && !ioctl_wait)     state_d = (byte_cnt == length_q) ? ST_FINISH : ST_FETCH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            length_q    <= '0;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
            ioctl_addr  <= '0;
            ioctl_dout  <= '0;
            ioctl_index <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                ioctl_index <= index;
                length_q    <= length;
                byte_cnt    <= '0;
                ioctl_addr  <= '0;
            end
            // byte_cnt advances right after the wr pulse, but ioctl_addr only picks it
            // up with the next byte, keeping addr/dout steady through HOLD and FETCH.
            if (src_hs) begin
                ioctl_dout <= src_data;
                ioctl_addr <= byte_cnt;
            end
            if (ioctl_wr) begin
                byte_cnt <= byte_cnt + 1'b1;
                gap_cnt  <= GAP_W'(1);
            end else if (state_q == ST_HOLD && !gap_ok) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

endmodule
